// File: rtl/song_loader_if.sv
// Host byte stream plus SRAM write pins of the song loader.
// master = host/top-level side, slave = the loader itself.
interface song_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [17:0] SRAM_A;
  logic [15:0] SRAM_DQ_OUT;
  logic        SRAM_DQ_OE;
  logic        SRAM_WE;
  logic        SRAM_CE;
  logic        SRAM_OE;
  logic        SRAM_LB;
  logic        SRAM_UB;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, SRAM_A, SRAM_DQ_OUT, SRAM_DQ_OE,
    input  SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, SRAM_A, SRAM_DQ_OUT, SRAM_DQ_OE,
    output SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB
  );
endinterface

// File: rtl/song_loader.sv
// Packs host bytes big-endian into 16-bit words and writes them to program SRAM; SONG_LOADER_CHECKSUM_EN adds a trailing checksum.
// Latency: low byte accepted at edge N -> WE low N+2 .. N+2+WE_CYCLES, rx_ready again at N+3+WE_CYCLES.
// Backpressure: rx_ready only in the byte-wait states, so a continuously valid stream loses nothing.
module song_loader #(
  parameter int WE_CYCLES = 3,
  parameter int MAX_WORDS = 262144
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          start,
  song_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [17:0]   word_count
);

  localparam int AW = $clog2(MAX_WORDS + 1);
  localparam int CW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

  typedef enum logic [3:0] {
    IDLE, WAIT_HI, WAIT_LO, SETUP, WRITE, HOLD, DONE, ERROR
`ifdef SONG_LOADER_CHECKSUM_EN
    , CHK_HI, CHK_LO
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   addr;
  logic [15:0]     word;
  logic [CW-1:0]   we_cnt;
  logic            rx_ready_q;
  logic            accept;
  logic            start_ok;
  logic            drive;
`ifdef SONG_LOADER_CHECKSUM_EN
  logic [15:0]     sum;
`endif

  logic [17:0]     sram_a_q;
  logic [15:0]     sram_dq_q;
  logic            sram_dq_oe_q, sram_we_q, sram_ce_q, sram_be_q;
  logic            cpu_hold_q, busy_q, done_q, error_q;

  function automatic logic rx_open(input state_t s);
`ifdef SONG_LOADER_CHECKSUM_EN
    return s inside {WAIT_HI, WAIT_LO, CHK_HI, CHK_LO};
`else
    return s inside {WAIT_HI, WAIT_LO};
`endif
  endfunction

  assign accept   = bus.rx_valid && rx_ready_q;
  assign start_ok = start && (state inside {IDLE, DONE, ERROR});
  assign drive    = state inside {SETUP, WRITE, HOLD};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: if (start) state_nxt = WAIT_HI;
      WAIT_HI:           if (accept) state_nxt = WAIT_LO;
      WAIT_LO:
        if (accept) state_nxt = (addr == AW'(MAX_WORDS)) ? ERROR : SETUP;
      SETUP:             state_nxt = WRITE;
      WRITE:             if (we_cnt == CW'(WE_CYCLES - 1)) state_nxt = HOLD;
      HOLD: begin
        if (word[15:12] == 4'b0000) begin
`ifdef SONG_LOADER_CHECKSUM_EN
          state_nxt = CHK_HI;
`else
          state_nxt = DONE;
`endif
        end else begin
          state_nxt = WAIT_HI;
        end
      end
`ifdef SONG_LOADER_CHECKSUM_EN
      CHK_HI:            if (accept) state_nxt = CHK_LO;
      CHK_LO:
        if (accept) state_nxt = ({word[15:8], bus.rx_data} == sum) ? DONE : ERROR;
`endif
      default:           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr   <= '0;
      word   <= '0;
      we_cnt <= '0;
`ifdef SONG_LOADER_CHECKSUM_EN
      sum    <= '0;
`endif
    end else begin
      if (start_ok) begin
        addr <= '0;
`ifdef SONG_LOADER_CHECKSUM_EN
        sum  <= '0;
`endif
      end
      case (state)
        WAIT_HI: if (accept) word[15:8] <= bus.rx_data;
        WAIT_LO: if (accept) word[7:0]  <= bus.rx_data;
        SETUP:   we_cnt <= '0;
        WRITE:   we_cnt <= we_cnt + CW'(1);
        HOLD: begin
          addr <= addr + AW'(1);
`ifdef SONG_LOADER_CHECKSUM_EN
          sum  <= sum + word;
`endif
        end
`ifdef SONG_LOADER_CHECKSUM_EN
        CHK_HI:  if (accept) word[15:8] <= bus.rx_data;
`endif
        default: ;
      endcase
    end
  end

  // Pins are decoded from the previous cycle's state, giving the one-cycle address/data setup before WE falls.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_ready_q   <= 1'b0;
      sram_a_q     <= '0;
      sram_dq_q    <= '0;
      sram_dq_oe_q <= 1'b0;
      sram_we_q    <= 1'b1;
      sram_ce_q    <= 1'b1;
      sram_be_q    <= 1'b1;
      cpu_hold_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      rx_ready_q   <= rx_open(state) && rx_open(state_nxt);
      sram_a_q     <= drive ? 18'(addr) : 18'd0;
      sram_dq_q    <= drive ? word : 16'd0;
      sram_dq_oe_q <= drive;
      sram_we_q    <= (state != WRITE);
      sram_ce_q    <= !drive;
      sram_be_q    <= !drive;
      cpu_hold_q   <= (state != DONE);
      busy_q       <= !(state inside {IDLE, DONE, ERROR});
      done_q       <= (state == DONE);
      error_q      <= (state == ERROR);
    end
  end

  assign bus.rx_ready    = rx_ready_q;
  assign bus.SRAM_A      = sram_a_q;
  assign bus.SRAM_DQ_OUT = sram_dq_q;
  assign bus.SRAM_DQ_OE  = sram_dq_oe_q;
  assign bus.SRAM_WE     = sram_we_q;
  assign bus.SRAM_CE     = sram_ce_q;
  assign bus.SRAM_OE     = 1'b1;
  assign bus.SRAM_LB     = sram_be_q;
  assign bus.SRAM_UB     = sram_be_q;
  assign cpu_hold        = cpu_hold_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;
  // A full 2^18-word load does not fit in 18 bits; only the low bits are reported.
  assign word_count      = 18'(addr);

endmodule

// File: tb/tb_song_loader.sv
// Scoreboard bench for song_loader: expected SRAM writes and final status are queued by a load model, monitors pop and compare.
module tb_song_loader;
  localparam int WE_CYC = 3;
  localparam int MAXW   = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        start = 1'b0;
  logic        cpu_hold, busy, done, error;
  logic [17:0] word_count;

  song_loader_if bus();

  song_loader #(.WE_CYCLES(WE_CYC), .MAX_WORDS(MAXW)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .bus(bus),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .word_count(word_count)
  );

  always #10 CLK = ~CLK;

  typedef struct packed { logic [17:0] a; logic [15:0] d; } wr_t;
  typedef struct packed { logic dn; logic er; logic hold; logic [17:0] cnt; } st_t;

  wr_t wq[$];
  st_t sq[$];
  int  total = 0;
  int  bad = 0;
  logic [15:0] wl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: captures each WE low pulse and compares it against the next expected write.
  initial begin : wr_mon
    int  lowc;
    wr_t cur;
    wr_t e;
    lowc = 0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        lowc = 0;
      end else if (bus.SRAM_WE === 1'b0) begin
        if (lowc == 0) begin
          cur.a = bus.SRAM_A;
          cur.d = bus.SRAM_DQ_OUT;
        end
        lowc++;
        check("rdy_during_write", bus.rx_ready, 0);
        check("ctl_during_write",
              {bus.SRAM_CE, bus.SRAM_OE, bus.SRAM_LB, bus.SRAM_UB, bus.SRAM_DQ_OE}, 5'b01001);
      end else if (lowc != 0) begin
        check("we_width", lowc, WE_CYC);
        check("hold_addr", bus.SRAM_A, cur.a);
        check("hold_dq_oe", bus.SRAM_DQ_OE, 1);
        if (wq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none", cur.a, cur.d);
        end else begin
          e = wq.pop_front();
          check("wr_addr", cur.a, e.a);
          check("wr_data", cur.d, e.d);
        end
        lowc = 0;
      end
    end
  end

  // Status monitor: whenever busy falls, the final load status is compared.
  initial begin : st_mon
    logic pb;
    st_t  e;
    pb = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST_N && pb && !busy) begin
        if (sq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_end: got done=%0b error=%0b expected no completion", done, error);
        end else begin
          e = sq.pop_front();
          check("st_done", done, e.dn);
          check("st_error", error, e.er);
          check("st_cpu_hold", cpu_hold, e.hold);
          check("st_word_count", word_count, e.cnt);
        end
      end
      pb = RST_N ? busy : 1'b0;
    end
  end

  task automatic do_start();
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    repeat (gap) @(negedge CLK);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (int t = 0; t < 100; t++) begin
      if (bus.rx_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    if (ok) @(negedge CLK);
    bus.rx_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL rx_timeout: got no rx_ready for byte %0h expected acceptance", b);
    end
  endtask

  task automatic poke_start();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (bus.SRAM_WE === 1'b0) begin
        seen = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL poke_wait: got no WE pulse expected one");
    end
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Load model: words are stored from address 0 until an end word or until capacity is exceeded.
  task automatic run_load(input logic [15:0] w[$], input int gap_max, input bit bad_chk,
                          input bit poke, input bit do_st);
    logic [7:0]  bytes[$];
    logic [15:0] s;
    st_t         e;
    int          n;
    bit          drained;
    n = 0;
    s = 16'd0;
    e = '0;
    for (int k = 0; k < w.size(); k++) begin
      bytes.push_back(w[k][15:8]);
      bytes.push_back(w[k][7:0]);
      if (n == MAXW) begin
        e.dn = 1'b0; e.er = 1'b1; e.hold = 1'b1; e.cnt = 18'(MAXW);
        break;
      end
      wq.push_back({18'(n), w[k]});
      s = s + w[k];
      n++;
      if (w[k][15:12] == 4'h0) begin
        e.dn = 1'b1; e.er = 1'b0; e.hold = 1'b0; e.cnt = 18'(n);
`ifdef SONG_LOADER_CHECKSUM_EN
        if (bad_chk) begin
          s = s + 16'd1;
          e.dn = 1'b0; e.er = 1'b1; e.hold = 1'b1;
        end
        bytes.push_back(s[15:8]);
        bytes.push_back(s[7:0]);
`endif
        break;
      end
    end
    sq.push_back(e);
    if (do_st) do_start();
    for (int k = 0; k < bytes.size(); k++) begin
      send_byte(bytes[k], (gap_max == 0) ? 0 : $urandom_range(gap_max, 0));
      if (poke && k == 1) poke_start();
    end
    drained = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (sq.size() == 0) begin
        drained = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    total++;
    if (!drained) begin
      bad++;
      $display("FAIL load_timeout: got busy=%0b expected load to finish", busy);
      sq.delete();
    end
    check("writes_left", wq.size(), 0);
    wq.delete();
  endtask

  initial begin : stim
    int          len;
    logic [15:0] rw;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    #3 RST_N = 1'b0;
    #4;
    check("rst_rx_ready", bus.rx_ready, 0);
    check("rst_sram_a", bus.SRAM_A, 0);
    check("rst_dq_out", bus.SRAM_DQ_OUT, 0);
    check("rst_dq_oe", bus.SRAM_DQ_OE, 0);
    check("rst_we_ce_oe_lb_ub",
          {bus.SRAM_WE, bus.SRAM_CE, bus.SRAM_OE, bus.SRAM_LB, bus.SRAM_UB}, 5'b11111);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_word_count", word_count, 0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    wl = {16'h8123, 16'h2045, 16'h0000};
    run_load(wl, 2, 1'b0, 1'b0, 1'b1);

    wl = {16'h9001, 16'h0000};
    run_load(wl, 0, 1'b0, 1'b0, 1'b1);

    // start while DONE restarts at address 0
    do_start();
    @(negedge CLK);
    check("restart_done", done, 0);
    check("restart_busy", busy, 1);
    check("restart_word_count", word_count, 0);
    check("restart_cpu_hold", cpu_hold, 1);
    wl = {16'h7abc, 16'h0def};
    run_load(wl, 3, 1'b0, 1'b0, 1'b0);

    wl = {16'h5555, 16'h6666, 16'h0777};
    run_load(wl, 1, 1'b0, 1'b1, 1'b1);

    wl = {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    run_load(wl, 1, 1'b0, 1'b0, 1'b1);
    check("overflow_cpu_hold", cpu_hold, 1);

`ifdef SONG_LOADER_CHECKSUM_EN
    wl = {16'h8123, 16'h0000};
    run_load(wl, 1, 1'b0, 1'b0, 1'b1);
    run_load(wl, 1, 1'b1, 1'b0, 1'b1);
`endif

    for (int it = 0; it < 20; it++) begin
      len = $urandom_range(6, 1);
      wl.delete();
      for (int k = 0; k < len; k++) begin
        rw = 16'($urandom);
        rw[15:12] = (k == len - 1 && len <= MAXW) ? 4'h0 : 4'($urandom_range(15, 1));
        wl.push_back(rw);
      end
      run_load(wl, $urandom_range(3, 0), 1'($urandom_range(1, 0)), 1'b0, 1'b1);
    end

    // async reset in the middle of a WE pulse
    do_start();
    send_byte(8'h91, 0);
    send_byte(8'h22, 0);
    for (int t = 0; t < 20; t++) begin
      if (bus.SRAM_WE === 1'b0) break;
      @(negedge CLK);
    end
    check("midwrite_we_low", bus.SRAM_WE, 0);
    #1 RST_N = 1'b0;
    #1;
    check("midrst_we", bus.SRAM_WE, 1);
    check("midrst_cpu_hold", cpu_hold, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_ce", bus.SRAM_CE, 1);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    wl = {16'h0abc};
    run_load(wl, 1, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/song_loader.md
Name: song_loader

Overview:
- Writer side of the program SRAM that the note-playing cpu reads.
- Accepts a byte stream from a host link (UART receiver or similar) with a valid/ready handshake. Packs bytes big-endian into 16-bit instruction words and writes them to SRAM at consecutive addresses from 0.
- Holds the cpu in reset (cpu_hold) until a complete program, terminated by an end instruction (word[15:12] == 4'b0000), is stored. Top level muxes SRAM pins between loader and cpu on cpu_hold.

Parameters:
- WE_CYCLES, 3, cycles SRAM_WE is held low per write (50 MHz clock, min 1).
- MAX_WORDS, 262144, word capacity; a write at address MAX_WORDS is an overflow error.

Ports:
- CLK  in  1  50 MHz system clock
- RST_N  in  1  async active-low reset
- start  in  1  one-cycle pulse: begin a new load at address 0
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept a byte
- SRAM_A  out  18  write address
- SRAM_DQ_OUT  out  16  write data
- SRAM_DQ_OE  out  1  drive DQ bus (tri-state at top level)
- SRAM_WE  out  1  active-low write enable
- SRAM_CE  out  1  active-low chip enable
- SRAM_OE  out  1  active-low output enable (loader holds 1)
- SRAM_LB  out  1  active-low lower byte enable
- SRAM_UB  out  1  active-low upper byte enable
- cpu_hold  out  1  1 = cpu held in reset, loader owns SRAM
- busy  out  1  load in progress
- done  out  1  program stored successfully (sticky until next start)
- error  out  1  load failed (sticky until next start)
- word_count  out  18  words written in current load

Behaviour:
- Reset is async, clock domain is CLK only. On RST_N=0 the block goes to state IDLE with:
  - rx_ready=0, SRAM_A=0, SRAM_DQ_OUT=0, SRAM_DQ_OE=0
  - SRAM_WE=1, SRAM_CE=1, SRAM_OE=1, SRAM_LB=1, SRAM_UB=1
  - cpu_hold=1, busy=0, done=0, error=0, word_count=0
- A byte is accepted when rx_valid && rx_ready at the clock edge. rx_ready=1 only in WAIT_HI and WAIT_LO.
- States and transitions:
  - IDLE: wait for start.
  - start is accepted in IDLE, DONE and ERROR; it is ignored in every other state. On accept: addr=0, word_count=0, done=0, error=0, cpu_hold=1, busy=1, go to WAIT_HI.
  - WAIT_HI: accepted byte goes to word[15:8], go to WAIT_LO.
  - WAIT_LO: accepted byte goes to word[7:0]. If addr == MAX_WORDS, go to ERROR with no write; otherwise go to SETUP.
  - SETUP (1 cycle): SRAM_A=addr, DQ_OUT=word, DQ_OE=1, CE=0, LB=UB=0, WE=1.
  - WRITE (WE_CYCLES cycles): same outputs as SETUP with WE=0.
  - HOLD (1 cycle): WE=1, address and data still driven (hold time). Then addr+1, word_count+1. If word[15:12]==0, go to DONE (or CHK_HI with the feature enabled); else go to WAIT_HI.
  - DONE: cpu_hold=0, busy=0, done=1, SRAM pins return to reset values.
  - ERROR: cpu_hold=1, busy=0, error=1, SRAM pins return to reset values.
- Latency: low byte accepted at edge N; WE falls at N+2; WE rises at N+2+WE_CYCLES; next rx_ready at N+3+WE_CYCLES.
- rx_valid held high with no gaps causes no byte loss, because rx_ready gates acceptance.
- Overflow boundary: MAX_WORDS words can be stored. The (MAX_WORDS+1)th word gives error=1 and word_count=MAX_WORDS.
- Address is 18-bit. Wrap to 0 never occurs; overflow is an error instead.
- Async reset mid-write: WE returns to 1 immediately (asynchronously), partial program is discarded, cpu_hold=1.

Optional Feature:
- Macro: SONG_LOADER_CHECKSUM_EN.
- Defined: the block keeps a 16-bit wrapping sum of every word written, including the end word. After the end word's HOLD it enters CHK_HI and then CHK_LO, accepting two bytes that form the checksum (high byte first). Match goes to DONE; mismatch goes to ERROR. No SRAM write occurs for the checksum bytes.
- Undefined: CHK_HI/CHK_LO do not exist and the end word leads directly to DONE.

Test Plan:
- Reset with RST_N=0 mid-WRITE -> SRAM_WE=1 asynchronously, cpu_hold=1, busy=0, done=0.
- start, then bytes 81 23 20 45 00 00 -> SRAM[0]=16'h8123, SRAM[1]=16'h2045, SRAM[2]=16'h0000, word_count=3, done=1, cpu_hold=0. Each WE low pulse lasts exactly 3 cycles.
- rx_valid held high continuously with bytes 90 01 00 00 -> rx_ready drops during SETUP/WRITE/HOLD, no byte lost, 2 words written.
- MAX_WORDS=4, five non-end words -> 4 writes, error=1, no 5th WE pulse, cpu_hold=1.
- start pulsed during WRITE -> ignored, load continues. start in DONE -> done=0, word_count=0, busy=1, next write at address 0.
- With SONG_LOADER_CHECKSUM_EN: words 8123, 0000 followed by checksum 81 23 -> done=1. The same words followed by checksum 81 24 -> error=1.
